// File: rtl/counting_gen_if.sv
// Bundles the job-control and symbol-stream signals of counting_gen.
//   master : requester side. Drives start/count/hold/gap and observes num/busy/done/frames_sent.
//   slave  : generator side (counting_gen).
interface counting_gen_if #(
   parameter int CNT_W  = 4,
   parameter int HOLD_W = 3,
   parameter int GAP_W  = 2
);
   logic              start;
   logic [CNT_W-1:0]  count;
   logic [HOLD_W-1:0] hold;
   logic [GAP_W-1:0]  gap;
   logic [1:0]        num;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  frames_sent;

   modport master (
      output start, count, hold, gap,
      input  num, busy, done, frames_sent
   );

   modport slave (
      input  start, count, hold, gap,
      output num, busy, done, frames_sent
   );
endinterface

// File: rtl/counting_gen.sv
// Symbol-stream generator that feeds the 1->2->3 sequence detector.
// A start request emits `count` frames. Each frame is 1, 2, 3 followed by
// `hold` extra 3s. Frames are separated by `gap` idle 0 symbols. There is no
// gap after the final frame. A one-cycle done pulse ends the job.
//   clk, reset : clock and synchronous active-high reset
//   bus.start  : job request, honoured only in IDLE
//   bus.count/hold/gap : job configuration, latched on the accepted start
//   bus.num    : registered 2-bit symbol stream
//   bus.busy   : job in progress
//   bus.done   : completion pulse
//   bus.frames_sent : frames completed in the current or last job
//
// state | meaning
// IDLE  | waiting for start, num=0
// SYM1  | emitting symbol 1
// SYM2  | emitting symbol 2
// SYM3  | emitting symbol 3 for 1+hold cycles
// GAP   | emitting gap idle 0 symbols between frames
// FIN   | one-cycle done pulse, then back to IDLE
module counting_gen #(
   parameter int CNT_W  = 4,
   parameter int HOLD_W = 3,
   parameter int GAP_W  = 2
) (
   input  logic           clk,
   input  logic           reset,
   counting_gen_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, SYM1, SYM2, SYM3, GAP, FIN} state_t;

   state_t            state, state_nx;
   logic [HOLD_W-1:0] hold_q, hold_cnt;
   logic [GAP_W-1:0]  gap_q, gap_cnt;
   logic [CNT_W-1:0]  rem_cnt;       // frames still to finish, including the current one
   logic [CNT_W-1:0]  frames_q;
   logic [1:0]        num_q, num_nx;
   logic              busy_q, busy_nx;
   logic              done_q, done_nx;
   logic              sym3_last;
   logic              accept;

   assign accept    = (state == IDLE) && bus.start;
   assign sym3_last = (state == SYM3) && (hold_cnt == '0);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.start) state_nx = (bus.count != '0) ? SYM1 : FIN;
         SYM1: state_nx = SYM2;
         SYM2: state_nx = SYM3;
         SYM3: begin
            if (hold_cnt == '0) begin
               if (rem_cnt == CNT_W'(1))  state_nx = FIN;
               else if (gap_q != '0)      state_nx = GAP;
               else                       state_nx = SYM1;
            end
         end
         GAP:  if (gap_cnt == '0) state_nx = SYM1;
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register on the same edge as the state.
   always_comb begin
      num_nx  = 2'd0;
      busy_nx = 1'b0;
      done_nx = 1'b0;
      unique case (state_nx)
         SYM1: begin num_nx = 2'd1; busy_nx = 1'b1; end
         SYM2: begin num_nx = 2'd2; busy_nx = 1'b1; end
         SYM3: begin num_nx = 2'd3; busy_nx = 1'b1; end
         GAP:  busy_nx = 1'b1;
         FIN:  done_nx = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         hold_q   <= '0;
         gap_q    <= '0;
         rem_cnt  <= '0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         frames_q <= '0;
         num_q    <= 2'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_nx;
         num_q  <= num_nx;
         busy_q <= busy_nx;
         done_q <= done_nx;

         if (accept) begin
            frames_q <= '0;
            if (bus.count != '0) begin
               rem_cnt <= bus.count;
               hold_q  <= bus.hold;
               gap_q   <= bus.gap;
            end
         end

         if ((state_nx == SYM3) && (state != SYM3))
            hold_cnt <= hold_q;
         else if ((state == SYM3) && (hold_cnt != '0))
            hold_cnt <= hold_cnt - HOLD_W'(1);

         if (sym3_last) begin
            frames_q <= frames_q + CNT_W'(1);
            rem_cnt  <= rem_cnt - CNT_W'(1);
         end

         // Gap counter is loaded with gap-1 so its terminal count of 0 marks the last idle cycle.
         if (sym3_last && (state_nx == GAP))
            gap_cnt <= gap_q - GAP_W'(1);
         else if ((state == GAP) && (gap_cnt != '0))
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   assign bus.num         = num_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_counting_gen.sv
module tb_counting_gen;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;
   int   got[$];
   int   busy_bad;
   int   ncyc;

   counting_gen_if #(.CNT_W(4), .HOLD_W(3), .GAP_W(2)) bus ();

   counting_gen #(.CNT_W(4), .HOLD_W(3), .GAP_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_seq(input string tag, input int exp[$]);
      chk({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s_sym%0d", tag, i), got[i], exp[i]);
   endtask

   // Runs one job. Samples on the falling edge: cycle 1 is the first cycle after
   // the start edge. Config inputs are scrambled once start is accepted, a
   // start is pulsed at cycle restart_at (0 = never) and during the FIN cycle.
   task automatic run_job(input int c, input int h, input int g, input int restart_at,
                          output int done_cyc);
      got.delete();
      busy_bad = 0;
      done_cyc = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.count = 4'(c);
      bus.hold  = 3'(h);
      bus.gap   = 2'(g);
      @(negedge clk);
      bus.start = 1'b0;
      bus.count = 4'(c ^ 5);
      bus.hold  = 3'(h ^ 3);
      bus.gap   = 2'(g ^ 1);
      for (int cyc = 1; cyc <= 400; cyc++) begin
         if (bus.done) begin
            done_cyc = cyc;
            break;
         end
         got.push_back(int'(bus.num));
         if (!bus.busy) busy_bad++;
         bus.start = (cyc == restart_at);
         @(negedge clk);
      end
      chk("fin_busy", int'(bus.busy), 0);
      chk("fin_num", int'(bus.num), 0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("post_fin_done", int'(bus.done), 0);
      chk("post_fin_busy", int'(bus.busy), 0);
      chk("post_fin_num", int'(bus.num), 0);
   endtask

   initial begin
      int zeros, ones, twos, threes;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.count = '0;
      bus.hold  = '0;
      bus.gap   = '0;
      repeat (2) @(negedge clk);
      chk("rst_num", int'(bus.num), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_frames", int'(bus.frames_sent), 0);
      reset = 1'b0;

      // count=1 hold=0 gap=0
      run_job(1, 0, 0, 0, ncyc);
      chk("j1_done_cyc", ncyc, 4);
      chk("j1_busy", busy_bad, 0);
      chk("j1_frames", int'(bus.frames_sent), 1);
      cmp_seq("j1", '{1, 2, 3});

      // count=2 hold=2 gap=1
      run_job(2, 2, 1, 0, ncyc);
      chk("j2_done_cyc", ncyc, 12);
      chk("j2_busy", busy_bad, 0);
      chk("j2_frames", int'(bus.frames_sent), 2);
      cmp_seq("j2", '{1, 2, 3, 3, 3, 0, 1, 2, 3, 3, 3});

      // count=3 back-to-back
      run_job(3, 0, 0, 0, ncyc);
      chk("j3_done_cyc", ncyc, 10);
      chk("j3_frames", int'(bus.frames_sent), 3);
      cmp_seq("j3", '{1, 2, 3, 1, 2, 3, 1, 2, 3});

      // count=0: frames_sent cleared, no symbols, immediate done
      run_job(0, 5, 2, 0, ncyc);
      chk("j0_done_cyc", ncyc, 1);
      chk("j0_frames", int'(bus.frames_sent), 0);
      cmp_seq("j0", '{});

      // start re-pulsed mid job is ignored
      run_job(2, 1, 2, 4, ncyc);
      chk("jr_done_cyc", ncyc, 11);
      chk("jr_frames", int'(bus.frames_sent), 2);
      cmp_seq("jr", '{1, 2, 3, 3, 0, 0, 1, 2, 3, 3});
      repeat (3) begin
         @(negedge clk);
         chk("jr_no_extra_done", int'(bus.done), 0);
      end

      // reset during SYM2 of frame 1
      bus.start = 1'b1;
      bus.count = 4'd2;
      bus.hold  = 3'd1;
      bus.gap   = 2'd1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ra_sym1", int'(bus.num), 1);
      @(negedge clk);
      chk("ra_sym2", int'(bus.num), 2);
      reset = 1'b1;
      @(negedge clk);
      chk("ra_num", int'(bus.num), 0);
      chk("ra_busy", int'(bus.busy), 0);
      chk("ra_frames", int'(bus.frames_sent), 0);
      chk("ra_done", int'(bus.done), 0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("ra_idle_num", int'(bus.num), 0);
         chk("ra_idle_done", int'(bus.done), 0);
      end

      // maximum config: 15*(3+7) + 14*3 = 192 symbol cycles
      run_job(15, 7, 3, 0, ncyc);
      chk("jm_done_cyc", ncyc, 193);
      chk("jm_busy", busy_bad, 0);
      chk("jm_frames", int'(bus.frames_sent), 15);
      chk("jm_len", got.size(), 192);
      zeros = 0; ones = 0; twos = 0; threes = 0;
      foreach (got[i]) begin
         case (got[i])
            0: zeros++;
            1: ones++;
            2: twos++;
            default: threes++;
         endcase
      end
      chk("jm_zeros", zeros, 42);
      chk("jm_ones", ones, 15);
      chk("jm_twos", twos, 15);
      chk("jm_threes", threes, 120);
      if (got.size() == 192) begin
         chk("jm_first", got[0], 1);
         chk("jm_gap_start", got[10], 0);
         chk("jm_frame2", got[13], 1);
         chk("jm_last", got[191], 3);
      end else begin
         chk("jm_len_guard", got.size(), 192);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/counting_gen.md
Name: counting_gen

Overview:
- Transmit side of the 2-bit symbol stream consumed by the downstream 1→2→3 sequence detector.
- On a start request it emits a programmed number of frames; each frame is the symbol run 1, 2, 3 with a configurable tail of repeated 3s.
- Consecutive frames are separated by a configurable run of idle 0 symbols.
- Used as a stimulus source and loopback driver for the detector path; purely synchronous, single clock.

Parameters:
- CNT_W, 4, width of the frame-count input and of the frames_sent counter.
- HOLD_W, 3, width of the hold input (extra 3-symbols per frame).
- GAP_W, 2, width of the gap input (idle 0 symbols between frames).

Ports:
- clk  input  1  system clock, all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- count  input  CNT_W  number of frames to send; latched on accepted start.
- hold  input  HOLD_W  extra cycles of symbol 3 after the first 3; latched on accepted start.
- gap  input  GAP_W  idle 0 cycles between frames; latched on accepted start.
- num  output  2  registered symbol stream to the detector.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.
- frames_sent  output  CNT_W  frames fully emitted in the current or last job.

Behaviour:
- Reset, synchronous: state=IDLE, num=0, busy=0, done=0, frames_sent=0, all latched config=0.
- Reset asserted mid-job aborts on that edge. The next cycle shows num=0 with no partial frame continuation.
- States: IDLE, SYM1, SYM2, SYM3, GAP, FIN.
  - Outputs are registered. num=1 in SYM1, 2 in SYM2, 3 in SYM3, 0 in IDLE/GAP/FIN.
- IDLE:
  - On start=1 with count≠0: latch count/hold/gap, clear frames_sent, go to SYM1. The first 1-symbol appears the cycle after start.
  - On start=1 with count=0: clear frames_sent, go to FIN. No symbols are emitted.
- SYM1 → SYM2 → SYM3 unconditionally, one cycle each.
- SYM3:
  - Lasts 1+hold cycles, tracked by an internal hold counter.
  - On its last cycle, frames_sent increments.
  - If frames remain and gap≠0, go to GAP. If frames remain and gap=0, go to SYM1 back-to-back (3 followed directly by 1).
  - If this was the last frame, go to FIN. No gap is emitted after the final frame.
- GAP: lasts exactly gap cycles with num=0, then goes to SYM1.
- FIN: done=1 and busy=0 for exactly one cycle, num=0, then IDLE.
- busy=1 in SYM1/SYM2/SYM3/GAP; 0 in IDLE/FIN.
- start while busy or in FIN is ignored and not queued. Config inputs are don't-care outside the start-accept edge.
- frames_sent holds its final value in IDLE until the next accepted start or reset.
- Max count (all ones) and max hold/gap must work without wrap. Internal counters are sized to the parameter widths; frames_sent never wraps within a job.
- Total job length from start edge to done: count·(3+hold) + (count−1)·gap cycles, plus 1 cycle for FIN.

Test Plan:
- Reset then start, count=1, hold=0, gap=0 → num sequence 1,2,3 on cycles 1–3 after start. done=1 on cycle 4, busy=1 on cycles 1–3, frames_sent=1.
- count=2, hold=2, gap=1 → num 1,2,3,3,3,0,1,2,3,3,3. done on the 12th cycle after start, frames_sent=2.
- count=3, gap=0, hold=0 → back-to-back 1,2,3,1,2,3,1,2,3 with no 0 between. done after 9 symbols.
- count=0 start → num stays 0. done pulses on cycle 1 after start, busy never rises, frames_sent=0.
- Start pulse re-asserted during a count=2 job → ignored: exactly 2 frames, single done pulse. Reset asserted in SYM2 of frame 1 → next cycle num=0, busy=0, frames_sent=0, no done.
- count=15, hold=7, gap=3 → 15·10+14·3=192 symbol cycles, done on cycle 193, frames_sent=15.
